adder_bist_engine: RTL

//  Hardware stimulus/checker for full_adder_four_bit: the on-chip counterpart of the file-driven adder bench.

---
 rtl/adder_bist_engine_if.sv | 25 ++
 rtl/adder_bist_engine.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/adder_bist_engine_if.sv
// Bus between the BIST engine and the 4-bit full adder under test.
// The engine (master) drives the operands; the adder (slave) returns {carry,sum}.
interface adder_bist_engine_if;
  logic [3:0] dut_a;
  logic [3:0] dut_b;
  logic       dut_cin;
  logic [3:0] dut_sum;
  logic       dut_carry;

  modport master (
    output dut_a,
    output dut_b,
    output dut_cin,
    input  dut_sum,
    input  dut_carry
  );

  modport slave (
    input  dut_a,
    input  dut_b,
    input  dut_cin,
    output dut_sum,
    output dut_carry
  );
endinterface

// File: rtl/adder_bist_engine.sv
// Exhaustive self-test engine for a 4-bit full adder: sweeps {cin,B,A}, checks each result, counts mismatches.
// Optional first-failure capture is enabled by defining ADDER_BIST_FAIL_LOG_EN.
module adder_bist_engine #(
  parameter int NUM_VECTORS = 512,
  parameter int ERR_W       = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [8:0]           vec_idx,
  adder_bist_engine_if.master  adder
`ifdef ADDER_BIST_FAIL_LOG_EN
  ,
  output logic                 fail_valid,
  output logic [8:0]           fail_idx,
  output logic [4:0]           fail_obs
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_e;

  localparam logic [8:0] LAST_IDX = 9'(NUM_VECTORS - 1);

  state_e             state_q, state_d;
  logic [8:0]         vec_idx_q, vec_idx_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic [3:0]         a_q, a_d;
  logic [3:0]         b_q, b_d;
  logic               cin_q, cin_d;

  logic               load_first;
  logic               in_check;
  logic [4:0]         golden;
  logic [4:0]         observed;
  logic               mismatch;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_DRIVE;
      S_DRIVE: state_d = S_CHECK;
      S_CHECK: state_d = (vec_idx_q == LAST_IDX) ? S_DONE : S_DRIVE;
      S_DONE:  if (start) state_d = S_DRIVE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs
  always_comb begin
    busy = (state_q == S_DRIVE) || (state_q == S_CHECK);
    done = (state_q == S_DONE);
    pass = (state_q == S_DONE) && (err_count_q == '0);
  end

  // Golden result comes from the registered operands, so it always matches what the adder sees.
  always_comb begin
    load_first = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    in_check   = (state_q == S_CHECK);
    golden     = 5'(a_q) + 5'(b_q) + 5'(cin_q);
    observed   = {adder.dut_carry, adder.dut_sum};
    mismatch   = in_check && (observed !== golden);

    vec_idx_d = vec_idx_q;
    if (load_first) begin
      vec_idx_d = '0;
    end else if (in_check && (vec_idx_q != LAST_IDX)) begin
      vec_idx_d = vec_idx_q + 9'd1;
    end

    a_d   = vec_idx_d[3:0];
    b_d   = vec_idx_d[7:4];
    cin_d = vec_idx_d[8];

    err_count_d = err_count_q;
    if (load_first) begin
      err_count_d = '0;
    end else if (mismatch && (err_count_q != {ERR_W{1'b1}})) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vec_idx_q   <= '0;
      err_count_q <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
    end else begin
      vec_idx_q   <= vec_idx_d;
      err_count_q <= err_count_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
    end
  end

  assign vec_idx       = vec_idx_q;
  assign err_count     = err_count_q;
  assign adder.dut_a   = a_q;
  assign adder.dut_b   = b_q;
  assign adder.dut_cin = cin_q;

`ifdef ADDER_BIST_FAIL_LOG_EN
  logic       fail_valid_q, fail_valid_d;
  logic [8:0] fail_idx_q, fail_idx_d;
  logic [4:0] fail_obs_q, fail_obs_d;

  // Only the first mismatch of a run is kept; later ones leave the log untouched.
  always_comb begin
    fail_valid_d = fail_valid_q;
    fail_idx_d   = fail_idx_q;
    fail_obs_d   = fail_obs_q;
    if (load_first) begin
      fail_valid_d = 1'b0;
      fail_idx_d   = '0;
      fail_obs_d   = '0;
    end else if (mismatch && !fail_valid_q) begin
      fail_valid_d = 1'b1;
      fail_idx_d   = vec_idx_q;
      fail_obs_d   = observed;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fail_valid_q <= 1'b0;
      fail_idx_q   <= '0;
      fail_obs_q   <= '0;
    end else begin
      fail_valid_q <= fail_valid_d;
      fail_idx_q   <= fail_idx_d;
      fail_obs_q   <= fail_obs_d;
    end
  end

  assign fail_valid = fail_valid_q;
  assign fail_idx   = fail_idx_q;
  assign fail_obs   = fail_obs_q;
`endif

endmodule
